mdu_wb: RTL and testbench
=========================

Name: mdu_wb

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers for the pipelined MIPS core. Sits beside the ALU in the E stage.
- Executes mult/multu/div/divu over a fixed number of cycles, and handles mthi/mtlo.
- Issues mfhi/mflo results as single-cycle register-file write requests: write enable, register address, write data and PC. These drive the register file's write port through the write-back mux.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1).
- DIV_CYCLES, 10, busy cycles for div/divu (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  issue request for op this cycle.
- op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 mfhi, 7 mflo.
- a  in  32  rs operand.
- b  in  32  rt operand.
- dst  in  5  destination register for mfhi/mflo.
- pc_in  in  32  PC of the issuing instruction.
- busy  out  1  arithmetic operation in progress.
- stall  out  1  combinational, equal to start & busy; the request is not accepted.
- hi  out  32  HI register.
- lo  out  32  LO register.
- wEn  out  1  register-file write request.
- wA  out  5  write address.
- wD  out  32  write data.
- pc_out  out  32  PC tagged on the write request.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs and registers go to 0 immediately, including hi, lo, busy, wEn, wA, wD, pc_out and the counter.
  - An in-flight operation is discarded and no HI/LO update occurs.
- Accept rule:
  - A request is accepted at a rising edge when start=1 and busy=0.
  - start=1 while busy=1 is ignored, and stall=1 for that cycle.
  - stall never depends on op.
- States: IDLE and RUN.
- IDLE, accept of op 0–3:
  - Latch operands and compute the result.
  - Load counter with MULT_CYCLES or DIV_CYCLES and go to RUN; busy=1 from the next cycle.
- RUN:
  - The counter decrements each edge.
  - At the edge where counter==1, write HI/LO, set busy=0 and return to IDLE.
  - busy is therefore high for exactly N cycles, and new HI/LO is visible in the cycle busy first reads 0.
- Arithmetic:
  - mult: signed 64-bit product, hi={prod[63:32]}, lo={prod[31:0]}.
  - multu: the same, unsigned.
  - div: lo=quotient truncated toward zero, hi=remainder with the sign of the dividend (a).
  - divu: unsigned.
  - div with a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0.
  - b=0 for div/divu: the busy period runs normally and HI/LO are left unchanged.
- mthi/mtlo (op 4/5): accepted only when busy=0. The next edge writes hi or lo with a; busy stays 0.
- mfhi/mflo (op 6/7):
  - Accepted only when busy=0.
  - At the next edge, register wEn=1, wA=dst, wD=hi or lo as of the accepting cycle, pc_out=pc_in.
  - wEn returns to 0 after exactly one cycle unless another mf is accepted back-to-back.
  - If dst=0, wEn stays 0 and wA, wD, pc_out still update.
- Outside a write pulse, wEn=0 and wA/wD/pc_out hold their last values.
- An mt and an mf accepted in consecutive cycles: the mf observes the mt value; there is no bypass hazard, because the mt write lands before the mf accept edge.
- The HI/LO update at the end of RUN and a new accept never coincide, because busy is still 1 in the final RUN cycle.

Test Plan:
1. Reset low mid-operation:
   - Stimulus: div a=100, b=7 accepted, then reset pulled low for 1 cycle, 3 cycles later.
   - Required: busy=0 and hi=lo=0 immediately; no later HI/LO change.
2. mult sequence:
   - Stimulus: mult a=0xFFFFFFFE (-2), b=3, then mflo dst=8, pc_in=0x3000.
   - Required: busy high for exactly 5 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFA; one-cycle wEn=1, wA=8, wD=0xFFFFFFFA, pc_out=0x3000.
3. Signed and unsigned divide:
   - div a=-7, b=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
   - divu a=7, b=2: lo=3, hi=1.
   - Both take 10 busy cycles.
4. Divide corner cases:
   - div by 0 with prior hi=0x11, lo=0x22: after 10 busy cycles hi=0x11, lo=0x22.
   - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
5. Stall and ignored request:
   - Stimulus: mfhi issued during mult busy.
   - Required: stall=1 each busy cycle, no wEn. Re-issued after busy falls, it yields the new hi.
6. Write-request edge cases:
   - mthi a=0xDEADBEEF then mfhi dst=0: hi=0xDEADBEEF, wEn stays 0.
   - mtlo a=5 then mflo dst=31 back-to-back: wEn=1, wA=31, wD=5.

Source files
------------

// File: rtl/mdu_wb.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Ports: clk, reset (async low), start/op/a/b/dst/pc_in in; busy, stall, hi, lo, wEn/wA/wD/pc_out out.
module mdu_wb #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  dst,
  input  logic [31:0] pc_in,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        wEn,
  output logic [4:0]  wA,
  output logic [31:0] wD,
  output logic [31:0] pc_out
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] ONE    = CW'(1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic [31:0]   hi_q, lo_q;
  logic [31:0]   res_hi_q, res_lo_q;
  logic          res_ok_q;
  logic          wen_q;
  logic [4:0]    wa_q;
  logic [31:0]   wd_q, pc_q;

  logic [63:0] prod_s, prod_u;
  logic [31:0] q_s, r_s, q_u, r_u;
  logic        bz, ovf;

  always_comb begin
    prod_s = $signed({{32{a[31]}}, a}) *
             $signed({{32{b[31]}}, b});
    prod_u = {32'b0, a} * {32'b0, b};
    bz  = (b == 32'd0);
    // the one signed quotient that does not fit in 32 bits
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    q_s = '0;
    r_s = '0;
    q_u = '0;
    r_u = '0;
    if (!bz) begin
      if (ovf) begin
        q_s = 32'h8000_0000;
        r_s = '0;
      end else begin
        q_s = $signed(a) / $signed(b);
        r_s = $signed(a) % $signed(b);
      end
      q_u = a / b;
      r_u = a % b;
    end
  end

  assign stall  = start & busy_q;
  assign busy   = busy_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign wEn    = wen_q;
  assign wA     = wa_q;
  assign wD     = wd_q;
  assign pc_out = pc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      res_ok_q <= 1'b0;
      wen_q    <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
      pc_q     <= '0;
    end else begin
      wen_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            unique case (op)
              3'd0: begin
                res_hi_q <= prod_s[63:32];
                res_lo_q <= prod_s[31:0];
                res_ok_q <= 1'b1;
                cnt_q    <= MULT_N;
                busy_q   <= 1'b1;
                state_q  <= RUN;
              end
              3'd1: begin
                res_hi_q <= prod_u[63:32];
                res_lo_q <= prod_u[31:0];
                res_ok_q <= 1'b1;
                cnt_q    <= MULT_N;
                busy_q   <= 1'b1;
                state_q  <= RUN;
              end
              3'd2: begin
                res_hi_q <= r_s;
                res_lo_q <= q_s;
                res_ok_q <= !bz;
                cnt_q    <= DIV_N;
                busy_q   <= 1'b1;
                state_q  <= RUN;
              end
              3'd3: begin
                res_hi_q <= r_u;
                res_lo_q <= q_u;
                res_ok_q <= !bz;
                cnt_q    <= DIV_N;
                busy_q   <= 1'b1;
                state_q  <= RUN;
              end
              3'd4: hi_q <= a;
              3'd5: lo_q <= a;
              3'd6, 3'd7: begin
                wen_q <= (dst != 5'd0);
                wa_q  <= dst;
                wd_q  <= op[0] ? lo_q : hi_q;
                pc_q  <= pc_in;
              end
            endcase
          end
        end
        RUN: begin
          if (cnt_q == ONE) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            if (res_ok_q) begin
              hi_q <= res_hi_q;
              lo_q <= res_lo_q;
            end
          end else begin
            cnt_q <= cnt_q - ONE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_wb.sv
// Self-checking bench for mdu_wb: vector table, corner sequences, random ops.
// Expected values come from constants and a plain-arithmetic HI/LO model.
module tb_mdu_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [4:0]  dst;
  logic [31:0] pc_in;
  logic        busy, stall;
  logic [31:0] hi, lo;
  logic        wEn;
  logic [4:0]  wA;
  logic [31:0] wD, pc_out;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] m_hi, m_lo;

  mdu_wb #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .dst(dst), .pc_in(pc_in),
    .busy(busy), .stall(stall), .hi(hi), .lo(lo),
    .wEn(wEn), .wA(wA), .wD(wD), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int exp_cycles(input logic [2:0] o);
    if (o < 3'd2) return 5;
    if (o < 3'd4) return 10;
    return 0;
  endfunction

  // Reference: HI/LO after an op, from plain 64-bit arithmetic.
  task automatic model(input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y);
    longint      sp, sq, sr;
    logic [63:0] t;
    case (o)
      3'd0: begin
        sp = longint'(signed'(x)) * longint'(signed'(y));
        t = sp; m_hi = t[63:32]; m_lo = t[31:0];
      end
      3'd1: begin
        t = 64'(x) * 64'(y);
        m_hi = t[63:32]; m_lo = t[31:0];
      end
      3'd2: if (y != 0) begin
        sq = longint'(signed'(x)) / longint'(signed'(y));
        sr = longint'(signed'(x)) % longint'(signed'(y));
        t = sq; m_lo = t[31:0];
        t = sr; m_hi = t[31:0];
      end
      3'd3: if (y != 0) begin
        m_lo = x / y;
        m_hi = x % y;
      end
      3'd4: m_hi = x;
      3'd5: m_lo = x;
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] d,
                        input logic [31:0] p, output int nc,
                        output logic we, output logic [4:0] wa_,
                        output logic [31:0] wd_, output logic [31:0] pc_,
                        output logic we2);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; dst = d; pc_in = p;
    @(negedge clk);
    start = 1'b0;
    we = wEn; wa_ = wA; wd_ = wD; pc_ = pc_out;
    nc = 0;
    while (busy && nc < 40) begin
      nc++;
      @(negedge clk);
    end
    @(negedge clk);
    we2 = wEn;
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [31:0] x, y;
    logic [4:0]  d;
    logic [31:0] p;
    logic [31:0] ehi, elo;
    logic        ewe;
    logic [31:0] ewd;
  } vec_t;

  vec_t vt[13];

  initial begin
    int nc;
    logic we, we2;
    logic [4:0] wa_;
    logic [31:0] wd_, pc_;
    logic [31:0] x, y;
    logic [2:0] o;
    logic [4:0] d;
    logic ism;

    vt[0]  = '{3'd0, 32'hFFFFFFFE, 32'd3, 5'd0, 32'h0,
               32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 32'h0};
    vt[1]  = '{3'd7, 32'h0, 32'h0, 5'd8, 32'h3000,
               32'hFFFFFFFF, 32'hFFFFFFFA, 1'b1, 32'hFFFFFFFA};
    vt[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2, 5'd0, 32'h0,
               32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 32'h0};
    vt[3]  = '{3'd3, 32'd7, 32'd2, 5'd0, 32'h0,
               32'd1, 32'd3, 1'b0, 32'h0};
    vt[4]  = '{3'd4, 32'h11, 32'h0, 5'd0, 32'h0,
               32'h11, 32'd3, 1'b0, 32'h0};
    vt[5]  = '{3'd5, 32'h22, 32'h0, 5'd0, 32'h0,
               32'h11, 32'h22, 1'b0, 32'h0};
    vt[6]  = '{3'd2, 32'd5, 32'd0, 5'd0, 32'h0,
               32'h11, 32'h22, 1'b0, 32'h0};
    vt[7]  = '{3'd3, 32'd9, 32'd0, 5'd0, 32'h0,
               32'h11, 32'h22, 1'b0, 32'h0};
    vt[8]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 5'd0, 32'h0,
               32'h0, 32'h80000000, 1'b0, 32'h0};
    vt[9]  = '{3'd4, 32'hDEADBEEF, 32'h0, 5'd0, 32'h0,
               32'hDEADBEEF, 32'h80000000, 1'b0, 32'h0};
    vt[10] = '{3'd6, 32'h0, 32'h0, 5'd0, 32'h44,
               32'hDEADBEEF, 32'h80000000, 1'b0, 32'hDEADBEEF};
    vt[11] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 32'h0,
               32'hFFFFFFFE, 32'h1, 1'b0, 32'h0};
    vt[12] = '{3'd0, 32'h80000000, 32'h80000000, 5'd0, 32'h0,
               32'h40000000, 32'h0, 1'b0, 32'h0};

    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    dst = '0; pc_in = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_wen", wEn, 0);
    chk("rst_wa", wA, 0);
    chk("rst_wd", wD, 0);
    chk("rst_pc", pc_out, 0);
    reset = 1'b1;

    // async reset in the middle of a divide
    run_op(3'd4, 32'h55, 0, 0, 0, nc, we, wa_, wd_, pc_, we2);
    chk("pre_rst_hi", hi, 32'h55);
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_hi", hi, 0);
    chk("post_rst_lo", lo, 0);

    // directed vector table
    for (int i = 0; i < 13; i++) begin
      run_op(vt[i].o, vt[i].x, vt[i].y, vt[i].d, vt[i].p,
             nc, we, wa_, wd_, pc_, we2);
      model(vt[i].o, vt[i].x, vt[i].y);
      chk($sformatf("v%0d_cyc", i), nc, exp_cycles(vt[i].o));
      chk($sformatf("v%0d_hi", i), hi, vt[i].ehi);
      chk($sformatf("v%0d_lo", i), lo, vt[i].elo);
      if (vt[i].o >= 3'd6) begin
        chk($sformatf("v%0d_wen", i), we, vt[i].ewe);
        chk($sformatf("v%0d_wa", i), wa_, vt[i].d);
        chk($sformatf("v%0d_wd", i), wd_, vt[i].ewd);
        chk($sformatf("v%0d_pc", i), pc_, vt[i].p);
        chk($sformatf("v%0d_wen2", i), we2, 0);
      end
    end

    // mfhi held during a multiply: stalled, then accepted
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'h10000; b = 32'h30000;
    model(3'd0, 32'h10000, 32'h30000);
    @(negedge clk);
    op = 3'd6; dst = 5'd4; pc_in = 32'h88;
    nc = 0;
    while (busy && nc < 40) begin
      #1;
      chk("stall_hi", stall, 1);
      chk("stall_nowen", wEn, 0);
      nc++;
      @(negedge clk);
    end
    chk("stall_cycles", nc, 5);
    chk("stall_lo", stall, 0);
    @(negedge clk);
    start = 1'b0;
    chk("reissue_wen", wEn, 1);
    chk("reissue_wa", wA, 4);
    chk("reissue_wd", wD, m_hi);
    chk("reissue_pc", pc_out, 32'h88);

    // mtlo then mflo back to back
    @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'd5;
    @(negedge clk);
    op = 3'd7; dst = 5'd31; pc_in = 32'h120;
    @(negedge clk);
    start = 1'b0;
    m_lo = 32'd5;
    chk("b2b_wen", wEn, 1);
    chk("b2b_wa", wA, 31);
    chk("b2b_wd", wD, 5);
    chk("b2b_lo", lo, 5);
    @(negedge clk);
    chk("b2b_wen_drop", wEn, 0);

    // random ops against the model
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      d = 5'($urandom);
      ism = (o >= 3'd6);
      wd_ = o[0] ? m_lo : m_hi;
      pc_ = $urandom;
      begin
        logic [31:0] ewd, epc;
        ewd = wd_; epc = pc_;
        run_op(o, x, y, d, epc, nc, we, wa_, wd_, pc_, we2);
        model(o, x, y);
        chk($sformatf("r%0d_cyc", i), nc, exp_cycles(o));
        chk($sformatf("r%0d_hi", i), hi, m_hi);
        chk($sformatf("r%0d_lo", i), lo, m_lo);
        if (ism) begin
          chk($sformatf("r%0d_wen", i), we, (d != 0));
          chk($sformatf("r%0d_wa", i), wa_, d);
          chk($sformatf("r%0d_wd", i), wd_, ewd);
          chk($sformatf("r%0d_pc", i), pc_, epc);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
